apb_rr_scheduler: RTL and testbench
===================================

// Module: apb_rr_scheduler
// PURPOSE
//  Shares one APB slave port between NUM_REQ requesters. Each requester has a valid/ready command port.
//  A round-robin arbiter grants one requester; an APB master FSM runs IDLE->SETUP->ACCESS.
//  A registered response returns to the granted requester. Bounded pready wait gives error responses.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   32  APB address width
//  DATA_W   32  APB data width
//  TIMEOUT  15  max ACCESS cycles with pready low before abort (1..255)
// PORTS
//  clk          in   1                clock, all flops rising-edge
//  reset_n      in   1                asynchronous active-low reset
//  req_valid_i  in   NUM_REQ          per-requester command valid
//  req_ready_o  out  NUM_REQ          one-hot accept; command taken when valid&ready
//  req_write_i  in   NUM_REQ          1=write, 0=read, per requester
//  req_addr_i   in   NUM_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata_i  in   NUM_REQ*DATA_W   packed write data, same packing
//  rsp_valid_o  out  NUM_REQ          one-cycle pulse to the requester whose transfer finished
//  rsp_rdata_o  out  DATA_W           read data, valid with rsp_valid_o; 0 for writes/errors
//  rsp_err_o    out  1                1 = transfer timed out, valid with rsp_valid_o
//  psel_o       out  1                APB select
//  penable_o    out  1                APB enable
//  paddr_o      out  ADDR_W           APB address
//  pwrite_o     out  1                APB direction
//  pwdata_o     out  DATA_W           APB write data
//  pready_i     in   1                APB ready from slave
//  prdata_i     in   DATA_W           APB read data
// BEHAVIOUR
//  Reset: state=IDLE; rr pointer=0; wait counter=0. All outputs 0, incl. captured addr/wdata/write.
//  Reset mid-transfer: psel/penable drop at once. No response is issued for the aborted transfer.
//  FSM:
//   - IDLE: if any req_valid_i, the arbiter's one-hot grant drives req_ready_o. This is combinational
//     from req_valid_i and is asserted only in IDLE. On accept, capture addr/wdata/write and grant index
//     into registers, then go to SETUP. With no valid, stay in IDLE.
//   - SETUP: psel=1, penable=0 -> ACCESS unconditionally.
//   - ACCESS: psel=1, penable=1. pready_i=1 -> IDLE and complete. If the wait counter reaches TIMEOUT
//     with pready_i=0 -> IDLE and abort.
//  psel/penable decode from registered state (no comb path from inputs). paddr/pwrite/pwdata are
//   registered and stable from SETUP to the end of ACCESS. They hold their last value in IDLE.
//  Wait counter: cleared on entering ACCESS; +1 each ACCESS cycle with pready_i=0. Abort when
//   count==TIMEOUT-1 and pready_i=0, i.e. after exactly TIMEOUT ACCESS cycles.
//  Response (registered, cycle after completion/abort; coincides with first IDLE cycle):
//   - rsp_valid_o[grant]=1 for 1 cycle.
//   - rsp_rdata_o = prdata_i captured when pready_i=1 for reads, else 0.
//   - rsp_err_o = 1 on abort, else 0.
//   - Outside the pulse, rsp_rdata_o=0 and rsp_err_o=0.
//  Min transfer = 3 cycles (IDLE accept, SETUP, ACCESS w/ pready). A new accept may occur in the same
//   IDLE cycle as the previous response pulse.
//  Round-robin: priority starts at the rr pointer and searches upward, wrapping modulo NUM_REQ.
//   On accept, pointer <= grant+1, wrapping NUM_REQ-1 -> 0. The pointer does not move without an accept.
//  A requester holding req_valid_i is served within NUM_REQ transfers (no starvation).
//  req_valid_i that drops while not ready is legal; the request is simply not taken.
//  pready_i/prdata_i are ignored outside ACCESS.
// STRUCTURE
//  Package apb_sched_pkg:
//   - typedef enum logic[1:0] {ST_IDLE=2'b00, ST_SETUP=2'b01, ST_ACCESS=2'b10} apb_state_t
//   - function clog2-safe index width IDX_W = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1
//  Sub-module rr_arbiter #(NUM_REQ):
//   - in: clk, reset_n, req, advance
//   - out: gnt (one-hot), gnt_idx
//   - owns the rr pointer; advance = accept
//  Top module: FSM, capture registers, wait counter, response registers.
// TESTING
//  1. Reset: hold reset_n=0 with req_valid_i=4'hF -> req_ready_o, psel_o, penable_o, rsp_valid_o, paddr_o
//     all 0; release -> first accept goes to req 0.
//  2. Single read: req 2 valid, addr=32'hDEAD_CAFE, pready_i=1 in ACCESS, prdata_i=32'h1234_5678 ->
//     accept cycle t, psel at t+1, penable at t+2, rsp_valid_o=4'b0100 and rdata=32'h1234_5678 at t+3.
//  3. Round-robin: req_valid_i=4'hF held, pready always 1 -> grant order 0,1,2,3,0 with 3 cycles between
//     accepts. Then req_valid_i=4'b1001 after grant 1 -> next grant 3, then 0.
//  4. Wait states: write from req 1, pready_i low 5 ACCESS cycles then high -> paddr/pwdata/pwrite stable
//     all 7 psel cycles; rsp_valid_o=4'b0010, rsp_err_o=0, rsp_rdata_o=0.
//  5. Timeout: TIMEOUT=15, pready_i tied 0 -> penable high exactly 15 cycles, then psel=0;
//     rsp_valid_o pulse with rsp_err_o=1, rdata=0; next request served normally.
//  6. Async reset mid-ACCESS: assert reset_n=0 between clocks -> psel_o/penable_o fall without a clock
//     edge; no rsp_valid_o after release; rr pointer back to 0.

Source files
------------

// File: rtl/apb_sched_pkg.sv
// Shared types and helpers for the APB round-robin scheduler.
//   apb_state_t : APB master phase encoding
//   idx_w()     : width of a requester index, never less than 1 bit
package apb_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at the rotating pointer and wraps
// upward modulo NUM_REQ. The pointer moves to grant+1 only when advance_i is
// high, so an un-accepted grant leaves the priority order untouched.
//   clk, reset_n : clock, async active-low reset (pointer -> 0)
//   req_i        : request vector
//   advance_i    : the current grant was accepted
//   gnt_o        : one-hot grant (combinational from req_i)
//   gnt_idx_o    : binary index of gnt_o
module rr_arbiter
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr + off < 2*NUM_REQ, so one conditional subtract is a full modulo
      sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (gnt_idx_o == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Shares one APB slave port between NUM_REQ valid/ready requesters.
// A round-robin arbiter picks a requester in IDLE; the APB master walks
// IDLE -> SETUP -> ACCESS and returns a one-cycle registered response to the
// granted requester. ACCESS is abandoned with an error after TIMEOUT cycles
// of pready_i low.
//
// state  | meaning
// IDLE   | bus idle, grant offered on req_ready_o
// SETUP  | psel=1, penable=0, captured command on the bus
// ACCESS | psel=1, penable=1, waiting for pready_i or timeout
//
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i : command ports
//   rsp_valid_o/rsp_rdata_o/rsp_err_o                          : response
//   psel_o/penable_o/paddr_o/pwrite_o/pwdata_o/pready_i/prdata_i : APB master
module apb_rr_scheduler
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = idx_w(NUM_REQ);

  apb_state_t          state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    gidx_q;
  logic                accept, done, abort;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_valid_i),
    .advance_i (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign accept = (state_q == ST_IDLE) && (|req_valid_i);

  // Gated by reset_n so no grant is offered while the block is held in reset.
  assign req_ready_o = (state_q == ST_IDLE && reset_n) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else if (wait_q == 8'(TIMEOUT-1)) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      gidx_q   <= '0;
    end else if (accept) begin
      paddr_q  <= req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
      pwdata_q <= req_wdata_i[gnt_idx*DATA_W +: DATA_W];
      pwrite_q <= req_write_i[gnt_idx];
      gidx_q   <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (done || abort) rsp_valid_q[gidx_q] <= 1'b1;
      rsp_rdata_q <= (done && !pwrite_q) ? prdata_i : '0;
      rsp_err_q   <= abort;
    end
  end

  assign psel_o      = (state_q != ST_IDLE);
  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pwrite_o    = pwrite_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
module tb_apb_rr_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [DW-1:0] rsp_rdata_o, pwdata_o, prdata_i;
  logic [AW-1:0] paddr_o;
  logic          rsp_err_o, psel_o, penable_o, pwrite_o, pready_i;

  int n_checks = 0;
  int n_fail   = 0;

  apb_rr_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid_i = 4'hF;
    pready_i = 1'b1;
    repeat (3) step();
    settle();
    n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
    n_checks++; if (psel_o !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b want 0", psel_o); end
    n_checks++; if (penable_o !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", penable_o); end
    n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); end
    n_checks++; if (paddr_o !== 32'h0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", paddr_o); end
    step();
    reset_n = 1'b1;
    settle();
    n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready_o); end
    step();
    req_valid_i = 4'h0;
    repeat (3) step();
  endtask

  task automatic test_single_read();
    step();
    req_addr_i[2*AW +: AW] = 32'hDEAD_CAFE;
    req_write_i = 4'b0000;
    prdata_i = 32'h1234_5678;
    pready_i = 1'b1;
    req_valid_i = 4'b0100;
    settle();
    n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL read_ready: got %b want 0100", req_ready_o); end
    step();
    req_valid_i = 4'b0000;
    settle();
    n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0) begin n_fail++; $display("FAIL read_setup: psel=%b penable=%b want 1 0", psel_o, penable_o); end
    n_checks++; if (paddr_o !== 32'hDEAD_CAFE || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL read_addr: paddr=%h pwrite=%b want deadcafe 0", paddr_o, pwrite_o); end
    step();
    settle();
    n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1) begin n_fail++; $display("FAIL read_access: psel=%b penable=%b want 1 1", psel_o, penable_o); end
    step();
    settle();
    n_checks++; if (rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL read_rsp_valid: got %b want 0100", rsp_valid_o); end
    n_checks++; if (rsp_rdata_o !== 32'h1234_5678 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL read_rsp_data: rdata=%h err=%b want 12345678 0", rsp_rdata_o, rsp_err_o); end
    n_checks++; if (psel_o !== 1'b0) begin n_fail++; $display("FAIL read_psel_drop: got %b want 0", psel_o); end
    step();
    settle();
    n_checks++; if (rsp_valid_o !== 4'b0000 || rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL read_rsp_clear: valid=%b rdata=%h want 0000 0", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_write_i = 4'b0000;
    prdata_i = 32'h0;
    pready_i = 1'b1;
    req_valid_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      settle();
      exp = 4'(1 << (k % 4));
      n_checks++; if (req_ready_o !== exp) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready_o, exp); end
      if (k > 0) begin
        exp = 4'(1 << ((k - 1) % 4));
        n_checks++; if (rsp_valid_o !== exp) begin n_fail++; $display("FAIL rr_rsp_%0d: got %b want %b", k, rsp_valid_o, exp); end
      end
      step();
      if (k == 5) req_valid_i = 4'b1001;
      settle();
      n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rr_setup_ready_%0d: got %b want 0000", k, req_ready_o); end
      step();
      settle();
      n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rr_access_ready_%0d: got %b want 0000", k, req_ready_o); end
      step();
    end
    settle();
    n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL rr_skip_to_3: got %b want 1000", req_ready_o); end
    n_checks++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL rr_rsp_1: got %b want 0010", rsp_valid_o); end
    repeat (3) step();
    settle();
    n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap_to_0: got %b want 0001", req_ready_o); end
    n_checks++; if (rsp_valid_o !== 4'b1000) begin n_fail++; $display("FAIL rr_rsp_3: got %b want 1000", rsp_valid_o); end
    step();
    req_valid_i = 4'b0000;
    repeat (2) step();
  endtask

  task automatic test_wait_states();
    step();
    req_addr_i[1*AW +: AW]  = 32'hA5A5_0004;
    req_wdata_i[1*DW +: DW] = 32'hCAFE_BABE;
    req_write_i = 4'b0010;
    req_valid_i = 4'b0010;
    pready_i = 1'b0;
    prdata_i = 32'hFFFF_FFFF;
    settle();
    n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL ws_ready: got %b want 0010", req_ready_o); end
    step();
    req_valid_i = 4'b0000;
    req_addr_i[1*AW +: AW]  = 32'h0;
    req_wdata_i[1*DW +: DW] = 32'h0;
    req_write_i = 4'b0000;
    settle();
    n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0 || paddr_o !== 32'hA5A5_0004 || pwdata_o !== 32'hCAFE_BABE || pwrite_o !== 1'b1) begin
      n_fail++; $display("FAIL ws_setup: psel=%b pen=%b addr=%h wdata=%h wr=%b want 1 0 a5a50004 cafebabe 1", psel_o, penable_o, paddr_o, pwdata_o, pwrite_o);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      pready_i = (i == 5);
      settle();
      n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1 || paddr_o !== 32'hA5A5_0004 || pwdata_o !== 32'hCAFE_BABE || pwrite_o !== 1'b1) begin
        n_fail++; $display("FAIL ws_access_%0d: psel=%b pen=%b addr=%h wdata=%h wr=%b want 1 1 a5a50004 cafebabe 1", i, psel_o, penable_o, paddr_o, pwdata_o, pwrite_o);
      end
    end
    step();
    pready_i = 1'b0;
    settle();
    n_checks++; if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL ws_rsp: valid=%b err=%b rdata=%h want 0010 0 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    n_checks++; if (psel_o !== 1'b0 || paddr_o !== 32'hA5A5_0004) begin n_fail++; $display("FAIL ws_idle_hold: psel=%b addr=%h want 0 a5a50004", psel_o, paddr_o); end
  endtask

  task automatic test_timeout();
    step();
    pready_i = 1'b0;
    prdata_i = 32'hAAAA_5555;
    req_write_i = 4'b0000;
    req_addr_i[3*AW +: AW] = 32'h0000_3000;
    req_valid_i = 4'b1000;
    settle();
    n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL to_ready: got %b want 1000", req_ready_o); end
    step();
    req_valid_i = 4'b0000;
    settle();
    n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0) begin n_fail++; $display("FAIL to_setup: psel=%b pen=%b want 1 0", psel_o, penable_o); end
    for (int i = 0; i < 15; i++) begin
      step();
      settle();
      n_checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1) begin n_fail++; $display("FAIL to_access_%0d: psel=%b pen=%b want 1 1", i, psel_o, penable_o); end
    end
    step();
    settle();
    n_checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0) begin n_fail++; $display("FAIL to_abort_bus: psel=%b pen=%b want 0 0", psel_o, penable_o); end
    n_checks++; if (rsp_valid_o !== 4'b1000 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL to_rsp: valid=%b err=%b rdata=%h want 1000 1 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    step();
    req_addr_i[0 +: AW] = 32'h0000_0100;
    prdata_i = 32'h0BAD_F00D;
    pready_i = 1'b1;
    req_valid_i = 4'b0001;
    settle();
    n_checks++; if (req_ready_o !== 4'b0001 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL to_next_ready: ready=%b err=%b want 0001 0", req_ready_o, rsp_err_o); end
    step();
    req_valid_i = 4'b0000;
    step();
    step();
    settle();
    n_checks++; if (rsp_valid_o !== 4'b0001 || rsp_rdata_o !== 32'h0BAD_F00D || rsp_err_o !== 1'b0) begin
      n_fail++; $display("FAIL to_next_rsp: valid=%b rdata=%h err=%b want 0001 0badf00d 0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
  endtask

  task automatic test_async_reset();
    step();
    pready_i = 1'b0;
    req_valid_i = 4'b0100;
    settle();
    n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL ar_ready: got %b want 0100", req_ready_o); end
    step();
    req_valid_i = 4'b0000;
    step();
    settle();
    n_checks++; if (penable_o !== 1'b1) begin n_fail++; $display("FAIL ar_in_access: pen=%b want 1", penable_o); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0) begin n_fail++; $display("FAIL ar_async_drop: psel=%b pen=%b want 0 0", psel_o, penable_o); end
    step();
    step();
    reset_n = 1'b1;
    pready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL ar_no_rsp_%0d: got %b want 0000", i, rsp_valid_o); end
      step();
    end
    req_valid_i = 4'hF;
    settle();
    n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL ar_ptr_reset: got %b want 0001", req_ready_o); end
    step();
    req_valid_i = 4'b0000;
    repeat (3) step();
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    pready_i = 1'b0;
    prdata_i = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
